// File: rtl/calc_pkg.sv
// Shared constants for the calculator display stage: status codes, digit count
// and active-low segment patterns ({dp,g,f,e,d,c,b,a}).
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;

    typedef logic [3:0] bcd_t;

    // "Err" right-aligned on digits 2..0, everything above blank.
    function automatic logic [7:0] err_pattern(input logic [2:0] idx);
        logic [7:0] pat;
        case (idx)
            3'd2:       pat = SEG_E;
            3'd1, 3'd0: pat = SEG_R;
            default:    pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/calc_display_ctrl_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 are blank.
module bcd_to_7seg
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 8'hC0;
            4'd1: seg = 8'hF9;
            4'd2: seg = 8'hA4;
            4'd3: seg = 8'hB0;
            4'd4: seg = 8'h99;
            4'd5: seg = 8'h92;
            4'd6: seg = 8'h82;
            4'd7: seg = 8'hF8;
            4'd8: seg = 8'h80;
            4'd9: seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display_ctrl.sv
// Eight-digit multiplexed display driver with shadow/commit frame buffering and error latch.
// Optional leading-zero blanking is enabled by defining CALC_DISP_LZB_EN.
module calc_display_ctrl
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       commit
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic                       err_q, err_d;
    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [2:0]                 scan_idx_q, scan_idx_d;
    logic [7:0]                 an_q, an_d;
    logic [7:0]                 seg_q, seg_d;
    logic                       commit_q, commit_d;

    logic       wr;
    logic       div_wrap;
    logic       lz_blank;
    bcd_t       cur_digit;
    logic [7:0] dec_seg;

    assign wr        = (status != ST_READY) && (pos <= 4'd7);
    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign cur_digit = disp_q[scan_idx_q];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef CALC_DISP_LZB_EN
    logic [31:0] disp_flat;
    assign disp_flat = disp_q;
    // Digit i blanks when it and every more significant digit are zero; digit 0 never blanks.
    assign lz_blank  = (scan_idx_q != 3'd0) && ((disp_flat >> {scan_idx_q, 2'b00}) == 32'd0);
`else
    assign lz_blank  = 1'b0;
`endif

    always_comb begin
        shadow_d   = shadow_q;
        disp_d     = disp_q;
        commit_d   = 1'b0;
        err_d      = err_q | (status == ST_ERR);
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
        scan_idx_d = div_wrap ? scan_idx_q + 3'd1 : scan_idx_q;
        an_d       = ~(8'b1 << scan_idx_q);
        seg_d      = dec_seg;

        if (wr) begin
            shadow_d[pos[2:0]] = data;
        end
        // The digit-7 value arrives on the commit edge itself, so bypass the shadow for it.
        if (wr && (pos == 4'd7)) begin
            disp_d   = {data, shadow_q[6:0]};
            commit_d = 1'b1;
        end

        if (err_q) begin
            seg_d = err_pattern(scan_idx_q);
        end else if (lz_blank) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q   <= '0;
            disp_q     <= '0;
            err_q      <= 1'b0;
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
            an_q       <= 8'hFF;
            seg_q      <= SEG_BLANK;
            commit_q   <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            err_q      <= err_d;
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            commit_q   <= commit_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign commit = commit_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Scoreboard bench for calc_display_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_calc_display_ctrl;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [7:0] seg;
    logic       commit;

    calc_display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clock  (clock),
        .reset  (reset),
        .status (status),
        .data   (data),
        .pos    (pos),
        .an     (an),
        .seg    (seg),
        .commit (commit)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] seg;
        bit         chk_seg;
    } exp_t;

    exp_t       exp_q[$];
    int         cq[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         rst_edge = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_seg[8];

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares an/seg against stamped expectations and every commit pulse against the commit queue.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_check cyc=%0d", mon_e.cyc);
            end else begin
                n_checks++;
                if (an !== mon_e.an) begin
                    n_fail++;
                    $display("FAIL an cyc=%0d actual=%h required=%h", cyc, an, mon_e.an);
                end
                if (mon_e.chk_seg) begin
                    n_checks++;
                    if (seg !== mon_e.seg) begin
                        n_fail++;
                        $display("FAIL seg cyc=%0d an=%h actual=%h required=%h", cyc, an, seg, mon_e.seg);
                    end
                end
            end
        end
        if (commit !== 1'b0) begin
            n_checks++;
            if (cq.size() > 0 && cq[0] == cyc) begin
                void'(cq.pop_front());
            end else begin
                n_fail++;
                $display("FAIL commit_unexpected cyc=%0d actual=%b required=0", cyc, commit);
            end
        end
        while (cq.size() > 0 && cq[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit_missing cyc=%0d actual=0 required=1", cq[0]);
            void'(cq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) tick();
    endtask

    function automatic int digit_at(input int e);
        return ((e - rst_edge - 1) / DIV) % 8;
    endfunction

    task automatic push_exp(input int e, input logic [7:0] seg_e, input bit chk);
        exp_t      x;
        logic [7:0] one;
        one       = 8'b1;
        x.cyc     = e;
        x.an      = ~(one << digit_at(e));
        x.seg     = seg_e;
        x.chk_seg = chk;
        exp_q.push_back(x);
    endtask

    task automatic push_blank(input int e);
        exp_t x;
        x.cyc     = e;
        x.an      = 8'hFF;
        x.seg     = 8'hFF;
        x.chk_seg = 1'b1;
        exp_q.push_back(x);
    endtask

    // Packed as {digit7, ..., digit0}, one byte each.
    task automatic set_exp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) exp_seg[i] = v[i*8 +: 8];
    endtask

    // One sample per digit slot, covering all eight digits.
    task automatic check_frame(input int start);
        int e;
        for (int k = 0; k < 8; k++) begin
            e = start + k * DIV;
            push_exp(e, exp_seg[digit_at(e)], 1'b1);
        end
        wait_until(start + 7 * DIV);
        tick();
    endtask

    task automatic idle();
        status = 2'b10;
        pos    = 4'hF;
        data   = 4'h0;
    endtask

    task automatic send(input int p, input logic [3:0] d, input logic [1:0] st);
        status = st;
        pos    = 4'(p);
        data   = d;
        tick();
    endtask

    task automatic frame(input logic [31:0] v, input logic [1:0] st7);
        for (int p = 0; p < 8; p++) send(p, v[p*4 +: 4], (p == 7) ? st7 : 2'b01);
        cq.push_back(cyc);
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick(); tick();
        push_blank(cyc);
        reset    = 1'b0;
        rst_edge = cyc;
        push_exp(cyc + 1, 8'hC0, 1'b1);
        tick();

        // Frame 00000345
`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_FF_B0_99_92);
`else
        set_exp(64'hC0_C0_C0_C0_C0_B0_99_92);
`endif
        frame(32'h0000_0345, 2'b01);
        check_frame(cyc + 1);

        // Partial frame: display must not change, no commit
        for (int p = 0; p < 4; p++) send(p, 4'h9, 2'b01);
        idle();
        check_frame(cyc + 1);

        // Only pos 7 written: shadow keeps the partial 9s
        send(7, 4'h0, 2'b01);
        cq.push_back(cyc);
        idle();
`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_90_90_90_90);
`else
        set_exp(64'hC0_C0_C0_C0_90_90_90_90);
`endif
        check_frame(cyc + 1);

`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_FF_FF_99_A4);
`else
        set_exp(64'hC0_C0_C0_C0_C0_C0_99_A4);
`endif
        frame(32'h0000_0042, 2'b01);
        check_frame(cyc + 1);

        // Non-BCD digit blanks and counts as non-zero for blanking
`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_FF_C0_99_A4);
`else
        set_exp(64'hC0_C0_C0_C0_FF_C0_99_A4);
`endif
        frame(32'h0000_A042, 2'b01);
        check_frame(cyc + 1);

`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_FF_FF_FF_C0);
`else
        set_exp(64'hC0_C0_C0_C0_C0_C0_C0_C0);
`endif
        frame(32'h0000_0000, 2'b01);
        check_frame(cyc + 1);

        // Scan order every cycle across a full 7 -> 0 wrap
        begin
            int s;
            s = cyc + 1;
            for (int e = s; e < s + 40; e++) push_exp(e, 8'h00, 1'b0);
            wait_until(s + 39);
            tick();
        end

        // Commit and error on the same edge: error display wins
        set_exp(64'hFF_FF_FF_FF_FF_86_AF_AF);
        frame(32'h0000_0012, 2'b00);
        check_frame(cyc + 1);

        // Reset clears err; then a one-cycle error pulse latches
        reset = 1'b1;
        tick();
        push_blank(cyc);
        tick();
        push_blank(cyc);
        reset    = 1'b0;
        rst_edge = cyc;
        push_exp(cyc + 1, 8'hC0, 1'b1);
        status = 2'b00;
        tick();
        idle();
        check_frame(cyc + 1);
        check_frame(cyc + 1);
        frame(32'h8765_4321, 2'b01);
        check_frame(cyc + 1);

        // Reset during pos 4 of a frame
        for (int p = 0; p < 4; p++) send(p, 4'h7, 2'b01);
        reset  = 1'b1;
        status = 2'b01;
        pos    = 4'd4;
        data   = 4'h7;
        tick();
        push_blank(cyc);
        reset    = 1'b0;
        rst_edge = cyc;
        idle();
`ifdef CALC_DISP_LZB_EN
        set_exp(64'hFF_FF_FF_FF_FF_FF_FF_C0);
`else
        set_exp(64'hC0_C0_C0_C0_C0_C0_C0_C0);
`endif
        check_frame(cyc + 1);

        // Partial frame before reset must be gone
        send(7, 4'h1, 2'b01);
        cq.push_back(cyc);
        idle();
        set_exp(64'hF9_C0_C0_C0_C0_C0_C0_C0);
        check_frame(cyc + 1);

        tick(); tick();
        n_checks++;
        if (exp_q.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover actual=%0d/%0d required=0/0", exp_q.size(), cq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_display_ctrl.md
# calc_display_ctrl

Downstream display stage for the calculator core: consumes the core's serial digit stream (`status`, `data`, `pos`) and drives eight time-multiplexed 7-segment displays. Incoming frames are collected in a shadow buffer and committed atomically, so a half-written frame is never shown. A refresh counter scans the eight digits continuously, independent of calculator activity. A latched error indication replaces the number with "Err".

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range ≥ 2.
- `clock` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `status` input 2: core status. 00 = error, 01 = busy (streaming), 10 = ready.
- `data` input 4: BCD digit presented by the core for position `pos`.
- `pos` input 4: digit index 0..7. Digit 0 is least significant. 4'hF means idle.
- `an` output 8: anode enables, active-low, one-hot-zero.
- `seg` output 8: {dp,g,f,e,d,c,b,a}, active-low. dp is always off (1).
- `commit` output 1: one-cycle pulse when a complete frame enters the display buffer.

## Operation
- Write strobe: `wr = (status != 2'b10) && (pos <= 7)`.
  - On `wr`, `shadow[pos] <= data`.
  - With `pos` = 8..15 or `status` = 10, nothing is written.
- Commit: when `wr` and `pos == 7` on the same edge, `disp <= {data, shadow[6:0]}`, so the digit-7 value arriving that cycle is included. `commit` goes high for the next cycle.
- Partial frames: if `pos` returns to 4'hF before reaching 7, `disp` is unchanged. The shadow keeps the partial contents, which later writes overwrite.
- Error latch: `err` is set on any cycle with `status == 2'b00`. It is cleared only by `reset`.
  - While `err` = 1, digits 2/1/0 show E, r, r and digits 7..3 are blank.
  - Shadow and commit logic keep running while `err` is set.
- Decode: `disp` values 0..9 map to the standard patterns. Values 10..15 display blank (`seg` = 8'hFF).
- Scan: `div_cnt` counts 0..REFRESH_DIV-1. On wrap, `scan_idx` (3 bits) increments modulo 8 (7 → 0).
  - `an` = ~(8'b1 << scan_idx).
  - `seg` = decode(`disp[scan_idx]`), or the error/blank pattern.
- Reset values: `an` = 8'hFF, `seg` = 8'hFF, `commit` = 0, `shadow` = 0, `disp` = 0, `err` = 0, `div_cnt` = 0, `scan_idx` = 0.

## Timing
- `an` and `seg` are registered. They reflect `scan_idx`, `disp` and `err` with one cycle of latency.
- Commit-to-visible latency: 1 cycle after the commit edge for the currently scanned digit. Worst case is 8·REFRESH_DIV cycles for a given digit.
- First scan output: the cycle after reset deasserts, `an` = 8'hFE (digit 0 lit).
- Each digit is lit for exactly REFRESH_DIV cycles. `an` changes on the cycle after the `div_cnt` wrap.
- Simultaneous `wr` to `pos == 7` and `status == 00`: the commit happens and `err` sets on the same edge. Err display wins from the next cycle.
- Reset asserted mid-frame or mid-scan: all state returns to reset values on that edge. Any partial frame is discarded.
- No back-pressure: a write on every cycle is accepted.

## Configuration
- `CALC_DISP_LZB_EN` defined: leading-zero blanking is applied.
  - Digit i (i ≥ 1) is blank when `disp[7:i]` are all zero.
  - Digit 0 is always shown, so a value of 0 displays as a single "0".
  - Blanking does not apply in the err display.
- `CALC_DISP_LZB_EN` not defined: all eight digits are shown, including leading zeros. Value 0 displays as "00000000".

## Structure
- Package `calc_pkg` holds:
  - status codes `ST_ERR` = 2'b00, `ST_BUSY` = 2'b01, `ST_READY` = 2'b10;
  - `NUM_DIGITS` = 8;
  - segment constants `SEG_BLANK` = 8'hFF, `SEG_E`, `SEG_R`.
- Sub-module `bcd_to_7seg`: combinational decoder, 4-bit in, 8-bit active-low out, blank for 10..15.
- The top level holds the shadow/display buffers, error latch, refresh divider, scan counter and output registers.

## Test plan
- Frame commit: after reset, stream digits 5,4,3,0,0,0,0,0 to `pos` 0..7 with `status` = 01. Expected: `commit` pulses once one cycle after the pos-7 edge; digit 0 shows `seg` 8'h92 and digit 1 shows 8'h99.
- Partial frame: stream `pos` 0..3 only, then set `pos` = F and `status` = 10. Expected: `disp` unchanged and no `commit` pulse.
- Scan order: with REFRESH_DIV = 4, `an` steps FE, FD, FB … 7F, FE, changing every 4 cycles. Check the wrap from 7F back to FE.
- Error: drive `status` = 00 for 1 cycle, then 10. Expected: digits 2..0 show E, r, r and digits 7..3 are blank; state persists until `reset`.
- Leading-zero blanking: commit value 00000042. With `CALC_DISP_LZB_EN`, digits 7..2 are blank. Without it, those digits show "0" (8'hC0).
- Reset mid-scan and mid-frame: assert `reset` during pos 4 of a frame. Expected: `an` = FF and `seg` = FF on the next cycle, then `disp` = 0 is shown.
